// File: rtl/instr_fetch_if.sv
// Fetch unit bus: ROM read port, decode handshake and execute redirect.
interface instr_fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              jump;
   logic [ADDR_W-1:0] jump_addr;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;

   modport master (
      input  jump,
      input  jump_addr,
      output rom_en,
      output rom_addr,
      input  rom_data,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      output jump,
      output jump_addr,
      input  rom_en,
      input  rom_addr,
      output rom_data,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential ROM reads into a credit-managed
// prefetch FIFO, presented to decode with the fetch address.
module instr_fetch #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input logic           clk,
   input logic           reset,
   instr_fetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            head;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] rd_addr;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW:0]       credit;
   logic              issue;
   logic              push;
   logic              pop;
   logic              empty;

   // An outstanding read already owns a slot, so it counts as credit.
   assign credit = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign issue  = !reset && !bus.jump && (credit < LIM);
   assign push   = inflight && !bus.jump && !reset;
   assign empty  = (count == '0);
   assign pop    = !empty && bus.instr_ready;
   assign head   = empty ? '0 : mem[rd_ptr];

   assign bus.rom_en      = issue;
   assign bus.rom_addr    = fpc;
   assign bus.instr       = head.data;
   assign bus.instr_pc    = head.addr;
   assign bus.instr_valid = !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         fpc      <= '0;
         inflight <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else if (bus.jump) begin
         fpc      <= bus.jump_addr;
         inflight <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue)
            fpc <= fpc + 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         rd_addr <= fpc;
      if (push)
         mem[wr_ptr] <= '{data: bus.rom_data, addr: rd_addr};
   end
endmodule
